dbg_ctrlr: RTL and testbench
============================

# dbg_ctrlr

Parametrised debug controller between the serial command decoder and the RV32 MCU. It accepts one decoded debug command at a time and drives MCU pause, resume, reset and register/memory access handshakes. It keeps a table of `NUM_BP` breakpoints with add and remove, and returns read data and status to the decoder. Completion is detected on a two-phase `mcu_busy` handshake with a timeout guard.

## Interface
- `NUM_BP`, 8: breakpoint slots. Range 1..16.
- `ADDR_W`, 32: address and PC width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 1024: maximum cycles to wait for an MCU handshake.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `debug_fn` in 4: command code.
  - PAUSE=0, RESUME=1, STEP=2, RESET=3, STATUS=4, BR_PT_ADD=5, BR_PT_RM=6, MEM_RD=7, MEM_WR=8, REG_RD=9, REG_WR=10.
- `addr` in ADDR_W: breakpoint, memory or register address.
- `d_in` in DATA_W: write data.
- `in_valid` in 1: command valid.
- `ctrlr_busy` out 1: controller cannot accept a command.
- `pc` in ADDR_W: PC of the instruction about to execute.
- `mcu_busy` in 1: MCU is acting on the current request.
- `d_rd` in DATA_W: MCU read data.
- `pause`, `resume`, `mcu_reset`, `mem_rd`, `mem_wr`, `rf_rd`, `rf_wr` out 1 each: request strobes, held for the whole handshake.
- `mcu_addr` out ADDR_W: access address.
- `mcu_d_in` out DATA_W: access write data.
- `out_valid` out 1: some request strobe is active.
- `rd_data` out DATA_W: read or status result.
- `rd_valid` out 1: one-cycle pulse, `rd_data` is valid.
- `err` out 1: one-cycle pulse, command rejected or timed out.
- `paused` out 1: MCU is known paused.
- `bp_count` out 5: number of valid breakpoints.

## Operation
- **Acceptance:** a command is accepted on a cycle with `in_valid` high and `ctrlr_busy` low.
  - `ctrlr_busy` is low only in IDLE with no breakpoint hit that cycle.
- **States:** IDLE, WAIT_PAUSE, WAIT_RESUME, WAIT_STEP_RUN, WAIT_RESET, WAIT_ACCESS.
- **PAUSE** → WAIT_PAUSE. Completion sets `paused`=1.
- **RESUME** → WAIT_RESUME. Completion clears `paused`.
- **STEP**, only when `paused`=1 → WAIT_STEP_RUN with `resume`. On completion, the next cycle enters WAIT_PAUSE with `pause`. When not paused: `err` pulse, stay IDLE.
- **RESET** → WAIT_RESET with `mcu_reset`. Completion clears `paused`. Breakpoints are kept.
- **STATUS:** no MCU traffic. `rd_data` = {zero-pad, `bp_count`, `paused`}, `rd_valid` pulse.
- **BR_PT_ADD:**
  - `addr` already present: no-op, no error.
  - Table not full: writes the lowest free slot, sets its valid bit, increments `bp_count`.
  - Table full: `err` pulse.
- **BR_PT_RM:** clears the valid bit of the matching slot and decrements `bp_count`. No match: `err` pulse.
- **MEM_RD, MEM_WR, REG_RD, REG_WR:** only when `paused`=1, otherwise `err` pulse.
  - Register and drive `mcu_addr`/`mcu_d_in` and the matching strobe, then go to WAIT_ACCESS.
  - On read completion, capture `d_rd` into `rd_data` and pulse `rd_valid`.
- **Breakpoint hit:** in IDLE, with `paused`=0, `pc` equals any valid entry.
  - Enter WAIT_PAUSE. A command presented that cycle is not accepted.
  - After the pause completes, resuming from the same PC does not re-trigger until `pc` changes.
- **Unknown codes (11..15):** `err` pulse, stay IDLE.

## Timing
- **Reset:** all outputs 0, `rd_data`=0, all valid bits cleared, `bp_count`=0, `paused`=0, state IDLE.
  - A reset asserted mid-handshake drops every strobe on the next edge.
- **Request latency:** accepted on edge N, strobe and `out_valid` registered high from cycle N+1.
- **Handshake completion** is two-phase:
  - A `seen_busy` flag is set on the first cycle `mcu_busy`=1.
  - The handshake completes on the first cycle afterward with `mcu_busy`=0.
  - The strobe deasserts and IDLE is entered on the following edge. `ctrlr_busy` is low one cycle later.
- **Timeout:** a cycle counter starts on strobe assertion. If it reaches TIMEOUT without completion: drop the strobe, pulse `err`, return to IDLE, leave `paused` unchanged.
- **Immediate commands:** STATUS, BR_PT_ADD and BR_PT_RM complete in 1 cycle. `rd_valid`/`err` pulse in cycle N+1 and `ctrlr_busy` stays low.
- **Same-cycle add/remove:** a breakpoint added on edge N can hit from cycle N+1. A removal on edge N prevents a hit from cycle N+1.
- **At most one** strobe is high at any time.

## Test plan
- **Pause then resume:** PAUSE accepted, MCU busy for 3 cycles → `pause` high 5 cycles, then `paused`=1; RESUME → `paused`=0.
- **Breakpoint table limits:** add 0x100..0x11C (8 entries) → `bp_count`=8; a 9th add → `err`; remove 0x108 → `bp_count`=7; remove 0x108 again → `err`.
- **Breakpoint hit priority:** breakpoint 0x40, `pc` steps 0x38, 0x3C, 0x40 → `pause` asserts the cycle after `pc`=0x40. A RESUME presented on the hit cycle is not accepted.
- **Register read while paused:** REG_RD `addr`=5, MCU returns `d_rd`=0xDEADBEEF → `rf_rd` held until completion, then one `rd_valid` with `rd_data`=0xDEADBEEF. MEM_WR while running → `err`, no strobe.
- **Step:** from paused, STEP → `resume` handshake then `pause` handshake, ending `paused`=1. STEP while running → `err`.
- **Timeout and reset:** with TIMEOUT=16 and `mcu_busy` stuck at 0 → `err` at cycle 16, IDLE. `reset_n` low during WAIT_ACCESS → all strobes 0 next cycle, `bp_count`=0.

Source files
------------

// File: rtl/dbg_ctrlr.sv
// ============================================================================
// Module      : dbg_ctrlr
// Description : Debug controller that turns decoded debug commands into MCU
//               pause/resume/reset/access handshakes and keeps a breakpoint table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbg_ctrlr #(
    parameter int NUM_BP  = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        debug_fn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              in_valid,
    output logic              ctrlr_busy,
    input  logic [ADDR_W-1:0] pc,
    input  logic              mcu_busy,
    input  logic [DATA_W-1:0] d_rd,
    output logic              pause,
    output logic              resume,
    output logic              mcu_reset,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              rf_rd,
    output logic              rf_wr,
    output logic [ADDR_W-1:0] mcu_addr,
    output logic [DATA_W-1:0] mcu_d_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              err,
    output logic              paused,
    output logic [4:0]        bp_count
);

    localparam int c_IDX_W   = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
    localparam int c_TIMER_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] c_FN_PAUSE  = 4'd0;
    localparam logic [3:0] c_FN_RESUME = 4'd1;
    localparam logic [3:0] c_FN_STEP   = 4'd2;
    localparam logic [3:0] c_FN_RESET  = 4'd3;
    localparam logic [3:0] c_FN_STATUS = 4'd4;
    localparam logic [3:0] c_FN_BP_ADD = 4'd5;
    localparam logic [3:0] c_FN_BP_RM  = 4'd6;
    localparam logic [3:0] c_FN_MEM_RD = 4'd7;
    localparam logic [3:0] c_FN_MEM_WR = 4'd8;
    localparam logic [3:0] c_FN_REG_RD = 4'd9;
    localparam logic [3:0] c_FN_REG_WR = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_WAIT_PAUSE    = 3'd1,
        S_WAIT_RESUME   = 3'd2,
        S_WAIT_STEP_RUN = 3'd3,
        S_WAIT_RESET    = 3'd4,
        S_WAIT_ACCESS   = 3'd5
    } state_t;

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_bp_addr [NUM_BP];
    logic [NUM_BP-1:0]      r_bp_valid;
    logic [4:0]             r_bp_count;
    logic                   r_paused;
    logic                   r_pause, r_resume, r_mcu_reset;
    logic                   r_mem_rd, r_mem_wr, r_rf_rd, r_rf_wr;
    logic [ADDR_W-1:0]      r_mcu_addr;
    logic [DATA_W-1:0]      r_mcu_d_in;
    logic [DATA_W-1:0]      r_rd_data;
    logic                   r_rd_valid;
    logic                   r_err;
    logic                   r_seen_busy;
    logic [c_TIMER_W-1:0]   r_timer;
    logic                   r_sup_valid;
    logic [ADDR_W-1:0]      r_sup_pc;

    logic [NUM_BP-1:0]      w_pc_match;
    logic [NUM_BP-1:0]      w_addr_match;
    logic                   w_free_found;
    logic [c_IDX_W-1:0]     w_free_idx;
    logic                   w_suppressed;
    logic                   w_hit;
    logic                   w_accept;
    logic                   w_done;
    logic                   w_tmo;

    always_comb begin
        w_pc_match   = '0;
        w_addr_match = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            w_pc_match[i]   = r_bp_valid[i] && (r_bp_addr[i] == pc);
            w_addr_match[i] = r_bp_valid[i] && (r_bp_addr[i] == addr);
        end
    end

    // Scan downwards so the lowest free slot is the one that sticks.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (!r_bp_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end
        end
    end

    // The PC we last paused at cannot re-trigger until the MCU moves on.
    assign w_suppressed = r_sup_valid && (pc == r_sup_pc);
    assign w_hit        = (r_state == S_IDLE) && !r_paused && (|w_pc_match) && !w_suppressed;
    assign ctrlr_busy   = (r_state != S_IDLE) || w_hit;
    assign w_accept     = in_valid && !ctrlr_busy;
    assign w_done       = r_seen_busy && !mcu_busy;
    assign w_tmo        = (r_timer == c_TIMER_W'(TIMEOUT - 1)) && !w_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_bp_valid  <= '0;
            r_bp_count  <= '0;
            r_paused    <= 1'b0;
            r_pause     <= 1'b0;
            r_resume    <= 1'b0;
            r_mcu_reset <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_rf_rd     <= 1'b0;
            r_rf_wr     <= 1'b0;
            r_mcu_addr  <= '0;
            r_mcu_d_in  <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_err       <= 1'b0;
            r_seen_busy <= 1'b0;
            r_timer     <= '0;
            r_sup_valid <= 1'b0;
            r_sup_pc    <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                r_bp_addr[i] <= '0;
            end
        end else begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            if (r_sup_valid && !w_suppressed) begin
                r_sup_valid <= 1'b0;
            end

            if (r_state == S_IDLE) begin
                r_seen_busy <= 1'b0;
                r_timer     <= '0;
                if (w_hit) begin
                    r_state <= S_WAIT_PAUSE;
                    r_pause <= 1'b1;
                end else if (w_accept) begin
                    case (debug_fn)
                        c_FN_PAUSE: begin
                            r_state <= S_WAIT_PAUSE;
                            r_pause <= 1'b1;
                        end
                        c_FN_RESUME: begin
                            r_state  <= S_WAIT_RESUME;
                            r_resume <= 1'b1;
                        end
                        c_FN_STEP: begin
                            if (r_paused) begin
                                r_state  <= S_WAIT_STEP_RUN;
                                r_resume <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                        c_FN_RESET: begin
                            r_state     <= S_WAIT_RESET;
                            r_mcu_reset <= 1'b1;
                        end
                        c_FN_STATUS: begin
                            r_rd_data  <= DATA_W'({r_bp_count, r_paused});
                            r_rd_valid <= 1'b1;
                        end
                        c_FN_BP_ADD: begin
                            if (|w_addr_match) begin
                                r_bp_count <= r_bp_count;
                            end else if (w_free_found) begin
                                r_bp_addr[w_free_idx]  <= addr;
                                r_bp_valid[w_free_idx] <= 1'b1;
                                r_bp_count             <= r_bp_count + 5'd1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                        c_FN_BP_RM: begin
                            if (|w_addr_match) begin
                                r_bp_valid <= r_bp_valid & ~w_addr_match;
                                r_bp_count <= r_bp_count - 5'd1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                        c_FN_MEM_RD, c_FN_MEM_WR, c_FN_REG_RD, c_FN_REG_WR: begin
                            if (r_paused) begin
                                r_state    <= S_WAIT_ACCESS;
                                r_mcu_addr <= addr;
                                r_mcu_d_in <= d_in;
                                r_mem_rd   <= (debug_fn == c_FN_MEM_RD);
                                r_mem_wr   <= (debug_fn == c_FN_MEM_WR);
                                r_rf_rd    <= (debug_fn == c_FN_REG_RD);
                                r_rf_wr    <= (debug_fn == c_FN_REG_WR);
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                        default: r_err <= 1'b1;
                    endcase
                end
            end else if (w_done || w_tmo) begin
                r_state     <= S_IDLE;
                r_pause     <= 1'b0;
                r_resume    <= 1'b0;
                r_mcu_reset <= 1'b0;
                r_mem_rd    <= 1'b0;
                r_mem_wr    <= 1'b0;
                r_rf_rd     <= 1'b0;
                r_rf_wr     <= 1'b0;
                r_seen_busy <= 1'b0;
                r_timer     <= '0;
                if (w_tmo) begin
                    r_err <= 1'b1;
                end else begin
                    case (r_state)
                        S_WAIT_PAUSE: begin
                            r_paused    <= 1'b1;
                            r_sup_valid <= 1'b1;
                            r_sup_pc    <= pc;
                        end
                        S_WAIT_RESUME, S_WAIT_RESET: r_paused <= 1'b0;
                        S_WAIT_STEP_RUN: begin
                            r_paused <= 1'b0;
                            r_state  <= S_WAIT_PAUSE;
                            r_pause  <= 1'b1;
                        end
                        S_WAIT_ACCESS: begin
                            if (r_mem_rd || r_rf_rd) begin
                                r_rd_data  <= d_rd;
                                r_rd_valid <= 1'b1;
                            end
                        end
                        default: r_paused <= r_paused;
                    endcase
                end
            end else begin
                if (mcu_busy) begin
                    r_seen_busy <= 1'b1;
                end
                r_timer <= r_timer + c_TIMER_W'(1);
            end
        end
    end

    assign pause     = r_pause;
    assign resume    = r_resume;
    assign mcu_reset = r_mcu_reset;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign rf_rd     = r_rf_rd;
    assign rf_wr     = r_rf_wr;
    assign out_valid = r_pause | r_resume | r_mcu_reset | r_mem_rd | r_mem_wr | r_rf_rd | r_rf_wr;
    assign mcu_addr  = r_mcu_addr;
    assign mcu_d_in  = r_mcu_d_in;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign err       = r_err;
    assign paused    = r_paused;
    assign bp_count  = r_bp_count;

endmodule

`default_nettype wire

// File: tb/tb_dbg_ctrlr.sv
// ============================================================================
// Module      : tb_dbg_ctrlr
// Description : Directed self-checking bench for dbg_ctrlr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbg_ctrlr;

    localparam int c_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  debug_fn;
    logic [31:0] addr, d_in, pc, d_rd, mcu_addr, mcu_d_in, rd_data;
    logic        in_valid, ctrlr_busy, mcu_busy;
    logic        pause, resume, mcu_reset, mem_rd, mem_wr, rf_rd, rf_wr;
    logic        out_valid, rd_valid, err, paused;
    logic [4:0]  bp_count;

    int n_checks = 0;
    int n_errors = 0;
    int hi;

    dbg_ctrlr #(.NUM_BP(8), .ADDR_W(32), .DATA_W(32), .TIMEOUT(c_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .debug_fn(debug_fn), .addr(addr), .d_in(d_in),
        .in_valid(in_valid), .ctrlr_busy(ctrlr_busy), .pc(pc), .mcu_busy(mcu_busy),
        .d_rd(d_rd), .pause(pause), .resume(resume), .mcu_reset(mcu_reset),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .rf_rd(rf_rd), .rf_wr(rf_wr),
        .mcu_addr(mcu_addr), .mcu_d_in(mcu_d_in), .out_valid(out_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .err(err), .paused(paused),
        .bp_count(bp_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] d);
        debug_fn = fn;
        addr     = a;
        d_in     = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic strobe_sel(input int w);
        case (w)
            1:       return pause;
            2:       return resume;
            default: return out_valid;
        endcase
    endfunction

    // Called in the first strobe cycle; MCU is busy for len cycles starting
    // dly cycles later. Returns how many cycles the watched strobe stayed high.
    task automatic handshake(input int w, input int dly, input int len, output int n_hi);
        n_hi = 0;
        for (int c = 0; c < 64; c++) begin
            if (!strobe_sel(w)) break;
            n_hi++;
            mcu_busy = (c >= dly) && (c < dly + len);
            tick();
        end
        mcu_busy = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        debug_fn = '0;
        addr     = '0;
        d_in     = '0;
        in_valid = 1'b0;
        pc       = '0;
        mcu_busy = 1'b0;
        d_rd     = '0;
        repeat (3) tick();
        check("reset_outputs", {pause, resume, mcu_reset, mem_rd, mem_wr, rf_rd, rf_wr,
              out_valid, rd_valid, err, paused, ctrlr_busy}, '0);
        check("reset_bp_count", bp_count, 0);
        check("reset_rd_data", rd_data, 0);
        reset_n = 1'b1;
        tick();

        // Pause then resume
        send(4'd0, '0, '0);
        check("pause_strobe", {pause, out_valid, ctrlr_busy}, 3'b111);
        handshake(1, 1, 3, hi);
        check("pause_hi_cycles", hi, 5);
        check("paused_set", {paused, ctrlr_busy}, 2'b10);
        send(4'd1, '0, '0);
        check("resume_strobe", resume, 1);
        handshake(2, 1, 2, hi);
        check("resume_hi_cycles", hi, 4);
        check("paused_clr", paused, 0);

        // Breakpoint table limits
        for (int i = 0; i < 8; i++) send(4'd5, 32'h100 + 32'(4 * i), '0);
        check("bp_full_count", bp_count, 8);
        send(4'd5, 32'h120, '0);
        check("bp_add_full_err", {err, ctrlr_busy}, 2'b10);
        check("bp_full_count2", bp_count, 8);
        send(4'd5, 32'h104, '0);
        check("bp_add_dup_noerr", err, 0);
        send(4'd6, 32'h108, '0);
        check("bp_rm_ok", {err, bp_count}, {1'b0, 5'd7});
        send(4'd6, 32'h108, '0);
        check("bp_rm_miss_err", {err, bp_count}, {1'b1, 5'd7});
        send(4'd5, 32'h200, '0);
        send(4'd4, '0, '0);
        check("status", {rd_valid, ctrlr_busy, rd_data}, {1'b1, 1'b0, 32'h10});
        tick();
        check("status_pulse_end", rd_valid, 0);
        send(4'd11, '0, '0);
        check("unknown_fn_err", {err, out_valid}, 2'b10);

        // Breakpoint hit priority
        send(4'd6, 32'h100, '0);
        send(4'd5, 32'h40, '0);
        pc = 32'h38;
        tick();
        pc = 32'h3C;
        tick();
        check("no_hit_before", {pause, ctrlr_busy}, 2'b00);
        pc       = 32'h40;
        debug_fn = 4'd1;
        in_valid = 1'b1;
        #1;
        check("hit_busy", ctrlr_busy, 1);
        tick();
        in_valid = 1'b0;
        check("hit_pause_not_resume", {pause, resume}, 2'b10);
        handshake(1, 1, 1, hi);
        check("hit_pause_hi", hi, 3);
        check("hit_paused", paused, 1);
        send(4'd1, '0, '0);
        handshake(2, 1, 1, hi);
        tick();
        tick();
        check("no_retrigger", {paused, pause, ctrlr_busy}, 3'b000);
        pc = 32'h1000;
        tick();

        // Accesses and step while running
        send(4'd8, 32'h20, 32'h1);
        check("memwr_running_err", {err, out_valid, mem_wr}, 3'b100);
        send(4'd2, '0, '0);
        check("step_running_err", {err, out_valid}, 2'b10);

        // Register read while paused
        send(4'd0, '0, '0);
        handshake(1, 1, 1, hi);
        d_rd = 32'hDEADBEEF;
        send(4'd9, 32'd5, '0);
        check("regrd_strobe", {rf_rd, out_valid, mcu_addr}, {2'b11, 32'd5});
        handshake(0, 1, 2, hi);
        check("regrd_hi", hi, 4);
        check("regrd_data", {rd_valid, rd_data}, {1'b1, 32'hDEADBEEF});
        tick();
        check("regrd_pulse_end", rd_valid, 0);

        // Step: resume handshake then pause handshake
        send(4'd2, '0, '0);
        check("step_resume", {resume, pause}, 2'b10);
        handshake(2, 1, 1, hi);
        check("step_run_hi", hi, 3);
        check("step_then_pause", {pause, resume, paused}, 3'b100);
        handshake(1, 1, 1, hi);
        check("step_pause_hi", hi, 3);
        check("step_paused", paused, 1);

        // Timeout with MCU never busy
        send(4'd7, 32'h80, '0);
        check("memrd_strobe", mem_rd, 1);
        handshake(0, 0, 0, hi);
        check("timeout_hi", hi, c_TIMEOUT);
        check("timeout_err", {err, out_valid, ctrlr_busy, paused}, 4'b1001);

        // RESET command clears paused
        send(4'd3, '0, '0);
        check("reset_strobe", mcu_reset, 1);
        handshake(0, 1, 1, hi);
        check("reset_cmd_paused", {paused, bp_count}, {1'b0, 5'd8});

        // Hardware reset during an access
        send(4'd0, '0, '0);
        handshake(1, 1, 1, hi);
        send(4'd10, 32'd3, 32'h55);
        check("regwr_strobe", {rf_wr, mcu_d_in}, {1'b1, 32'h55});
        mcu_busy = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        mcu_busy = 1'b0;
        check("reset_mid_strobes", {pause, resume, mcu_reset, mem_rd, mem_wr, rf_rd, rf_wr,
              out_valid}, 8'h00);
        check("reset_mid_state", {bp_count, paused}, 6'd0);
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
